// File: rtl/qdr2p_user_emulator.sv
`default_nettype none
// ============================================================================
// Module      : qdr2p_user_emulator
// Description : Behavioural stand-in for a QDR-II+ controller user port.
//               After reset, it sweeps the backing array to zero one word per
//               cycle (CLEAR). It then accepts one read and one write every
//               cycle (RUN). Reads return after exactly READ_LATENCY cycles,
//               in order. Requests seen while not ready are dropped and
//               counted.
//
// Parameters  : RAM_WIDTH    - RAM data pins per beat. A user word is
//                              CTRL_WIDTH = 4*RAM_WIDTH bits wide.
//               ADDR_BITS    - user address width.
//               DEPTH_BITS   - the array holds 2^DEPTH_BITS words
//                              (1..ADDR_BITS). Upper address bits alias.
//               READ_LATENCY - cycles from rd_en to rd_valid (2..16).
//
// Ports       : clk_ctl         in   1          sole clock, rising edge
//               rst             in   1          synchronous active-high reset
//               rd_en           in   1          read request
//               rd_addr         in   ADDR_BITS  read word address
//               wr_en           in   1          write request
//               wr_addr         in   ADDR_BITS  write word address
//               wr_data         in   CTRL_WIDTH write data (same cycle)
//               rd_valid        out  1          one-cycle pulse per read
//               rd_data         out  CTRL_WIDTH read data, held between reads
//               ready           out  1          array cleared, requests taken
//               drop_count      out  16         dropped requests, saturating
//               rd_count        out  32         (QDR2P_EMU_STATS_EN) reads done
//               wr_count        out  32         (QDR2P_EMU_STATS_EN) writes done
//               collision_count out  16         (QDR2P_EMU_STATS_EN) same-index
//                                               read+write cycles, saturating
//
// Options     : define QDR2P_EMU_STATS_EN to add the statistics counters.
//
// Revision    : 1.0 - initial release
// ============================================================================
module qdr2p_user_emulator #(
  parameter int RAM_WIDTH    = 36,
  parameter int ADDR_BITS    = 18,
  parameter int DEPTH_BITS   = 10,
  parameter int READ_LATENCY = 4
) (
  input  logic                     clk_ctl,
  input  logic                     rst,
  input  logic                     rd_en,
  input  logic [ADDR_BITS-1:0]     rd_addr,
  input  logic                     wr_en,
  input  logic [ADDR_BITS-1:0]     wr_addr,
  input  logic [4*RAM_WIDTH-1:0]   wr_data,
  output logic                     rd_valid,
  output logic [4*RAM_WIDTH-1:0]   rd_data,
  output logic                     ready,
  output logic [15:0]              drop_count
`ifdef QDR2P_EMU_STATS_EN
  ,
  output logic [31:0]              rd_count,
  output logic [31:0]              wr_count,
  output logic [15:0]              collision_count
`endif
);

  localparam int CTRL_WIDTH = 4 * RAM_WIDTH;
  localparam int WORDS      = 1 << DEPTH_BITS;
  // Stages ahead of the rd_valid/rd_data output register. Stage 0 is the
  // array read, so the output register lands exactly READ_LATENCY-1 edges
  // after the sampling edge. That is cycle N+READ_LATENCY for a request
  // presented in cycle N.
  localparam int PIPE       = READ_LATENCY - 1;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t                  state;
  // One bit wider than the index. The top bit marks "every word swept",
  // which gives the single idle CLEAR cycle before RUN.
  logic [DEPTH_BITS:0]     sweep;

  logic [CTRL_WIDTH-1:0]   mem [WORDS];

  logic [DEPTH_BITS-1:0]   rd_idx;
  logic [DEPTH_BITS-1:0]   wr_idx;
  logic                    rd_go;
  logic                    wr_go;
  logic                    sweep_wr;
  logic [16:0]             drop_sum;
  logic [15:0]             drop_next;

  logic [PIPE-1:0]         v_pipe;
  logic [CTRL_WIDTH-1:0]   d_pipe [PIPE];

  // Upper address bits alias onto the array and are intentionally ignored.
  logic                    unused_addr_bits;
  assign unused_addr_bits = ^{rd_addr, wr_addr};

  assign rd_idx   = rd_addr[DEPTH_BITS-1:0];
  assign wr_idx   = wr_addr[DEPTH_BITS-1:0];
  assign rd_go    = (state == RUN) && rd_en && !rst;
  assign wr_go    = (state == RUN) && wr_en && !rst;
  assign sweep_wr = (state == CLEAR) && !sweep[DEPTH_BITS] && !rst;

  // Saturating drop accumulator. Each of rd_en and wr_en counts one.
  assign drop_sum  = {1'b0, drop_count} + {16'd0, rd_en} + {16'd0, wr_en};
  assign drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

  // --------------------------------------------------------------------------
  // Control FSM: CLEAR sweeps the array, RUN serves requests.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_ctl) begin
    if (rst) begin
      state      <= CLEAR;
      sweep      <= '0;
      ready      <= 1'b0;
      drop_count <= 16'd0;
    end else begin
      case (state)
        CLEAR: begin
          drop_count <= drop_next;
          if (sweep[DEPTH_BITS]) begin
            state <= RUN;
            ready <= 1'b1;
          end else begin
            sweep <= sweep + 1'b1;
          end
        end
        RUN: begin
          ready <= 1'b1;
        end
        default: begin
          state <= CLEAR;
          sweep <= '0;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Backing array. The sweep and user writes are exclusive by state.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_ctl) begin
    if (sweep_wr) begin
      mem[sweep[DEPTH_BITS-1:0]] <= '0;
    end else if (wr_go) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // --------------------------------------------------------------------------
  // Read pipeline. The array is sampled on the same edge that commits a
  // same-cycle write, so a colliding read sees the old word.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_ctl) begin
    if (rst) begin
      v_pipe[0] <= 1'b0;
    end else begin
      v_pipe[0] <= rd_go;
    end
  end

  always_ff @(posedge clk_ctl) begin
    if (rd_go) begin
      d_pipe[0] <= mem[rd_idx];
    end
  end

  for (genvar i = 1; i < PIPE; i++) begin : g_pipe
    always_ff @(posedge clk_ctl) begin
      if (rst) begin
        v_pipe[i] <= 1'b0;
      end else begin
        v_pipe[i] <= v_pipe[i-1];
      end
    end

    always_ff @(posedge clk_ctl) begin
      d_pipe[i] <= d_pipe[i-1];
    end
  end

  // Output register. rd_data only moves on a valid return, so it holds the
  // last delivered word between pulses.
  always_ff @(posedge clk_ctl) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= v_pipe[PIPE-1];
      if (v_pipe[PIPE-1]) begin
        rd_data <= d_pipe[PIPE-1];
      end
    end
  end

`ifdef QDR2P_EMU_STATS_EN
  // --------------------------------------------------------------------------
  // Statistics: executed reads and writes wrap. Collisions saturate.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_ctl) begin
    if (rst) begin
      rd_count        <= 32'd0;
      wr_count        <= 32'd0;
      collision_count <= 16'd0;
    end else begin
      if (rd_go) begin
        rd_count <= rd_count + 32'd1;
      end
      if (wr_go) begin
        wr_count <= wr_count + 32'd1;
      end
      if (rd_go && wr_go && (rd_idx == wr_idx) && (collision_count != 16'hFFFF)) begin
        collision_count <= collision_count + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_qdr2p_user_emulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_qdr2p_user_emulator
// Description : Randomised self-checking bench for qdr2p_user_emulator. A
//               transaction-level model holds the array contents, a queue of
//               pending read returns, and the ready/drop/statistics state.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qdr2p_user_emulator;

  localparam int RW    = 36;
  localparam int CW    = 4 * RW;
  localparam int AB    = 18;
  localparam int DB    = 4;
  localparam int WORDS = 1 << DB;
  localparam int L     = 4;

  logic           clk;
  logic           rst;
  logic           rd_en;
  logic [AB-1:0]  rd_addr;
  logic           wr_en;
  logic [AB-1:0]  wr_addr;
  logic [CW-1:0]  wr_data;
  logic           rd_valid;
  logic [CW-1:0]  rd_data;
  logic           ready;
  logic [15:0]    drop_count;
`ifdef QDR2P_EMU_STATS_EN
  logic [31:0]    rd_count;
  logic [31:0]    wr_count;
  logic [15:0]    collision_count;
`endif

  qdr2p_user_emulator #(
    .RAM_WIDTH    (RW),
    .ADDR_BITS    (AB),
    .DEPTH_BITS   (DB),
    .READ_LATENCY (L)
  ) dut (
    .clk_ctl         (clk),
    .rst             (rst),
    .rd_en           (rd_en),
    .rd_addr         (rd_addr),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .rd_valid        (rd_valid),
    .rd_data         (rd_data),
    .ready           (ready),
    .drop_count      (drop_count)
`ifdef QDR2P_EMU_STATS_EN
    ,
    .rd_count        (rd_count),
    .wr_count        (wr_count),
    .collision_count (collision_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  typedef struct {
    int            due;
    logic [CW-1:0] data;
  } exp_t;

  exp_t          exp_q [$];
  logic [CW-1:0] m_mem [WORDS];
  logic [CW-1:0] m_last;
  logic          m_ready;
  int            m_drop;
  int            m_clr;
  logic [31:0]   m_rdc;
  logic [31:0]   m_wrc;
  int            m_col;
  bit            armed;
  int            cyc;
  logic          obs_ready;
  bit            win;
  int            win_valid;

  int n_checks;
  int n_fail;

  task automatic check_eq(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [CW-1:0] rand_word();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[CW-1:0];
  endfunction

  function automatic logic [AB-1:0] rand_addr();
    logic [31:0] t;
    t = $urandom;
    return t[AB-1:0];
  endfunction

  // One clock cycle: check the outputs for this cycle, then present the
  // inputs and advance the model as the next edge will see them.
  task automatic do_cycle(input logic r, input logic re, input logic [AB-1:0] ra,
                          input logic we, input logic [AB-1:0] wa, input logic [CW-1:0] wd);
    exp_t e;
    logic ev;
    @(negedge clk);
    if (armed) begin
      ev = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e      = exp_q.pop_front();
        ev     = 1'b1;
        m_last = e.data;
      end
      check_eq("rd_valid", CW'(rd_valid), CW'(ev));
      check_eq("rd_data", rd_data, m_last);
      check_eq("ready", CW'(ready), CW'(m_ready));
      check_eq("drop_count", CW'(drop_count), CW'(m_drop));
`ifdef QDR2P_EMU_STATS_EN
      check_eq("rd_count", CW'(rd_count), CW'(m_rdc));
      check_eq("wr_count", CW'(wr_count), CW'(m_wrc));
      check_eq("collision_count", CW'(collision_count), CW'(m_col));
`endif
      if (win && rd_valid === 1'b1) win_valid++;
    end
    obs_ready = ready;

    rst     = r;
    rd_en   = re;
    rd_addr = ra;
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;

    if (r) begin
      exp_q.delete();
      m_ready = 1'b0;
      m_drop  = 0;
      m_clr   = 0;
      m_last  = '0;
      m_rdc   = 32'd0;
      m_wrc   = 32'd0;
      m_col   = 0;
      armed   = 1'b1;
    end else if (m_ready) begin
      if (re) begin
        e.due  = cyc + L;
        e.data = m_mem[ra[DB-1:0]];
        exp_q.push_back(e);
        m_rdc = m_rdc + 32'd1;
      end
      if (we) begin
        m_mem[wa[DB-1:0]] = wd;
        m_wrc = m_wrc + 32'd1;
      end
      if (re && we && ra[DB-1:0] == wa[DB-1:0] && m_col < 65535) m_col++;
    end else begin
      m_drop = m_drop + int'(re) + int'(we);
      if (m_drop > 65535) m_drop = 65535;
      // Clearing takes one cycle per word plus one cycle to enter RUN.
      m_clr++;
      if (m_clr == WORDS + 1) begin
        m_ready = 1'b1;
        for (int k = 0; k < WORDS; k++) m_mem[k] = '0;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) do_cycle(1'b0, 1'b0, '0, 1'b0, '0, '0);
  endtask

  // Call right after the cycle that releases reset. Issues n_drop requests
  // while clearing, then waits for ready and returns the cycles taken.
  task automatic wait_ready(input int n_drop, input bit both, output int rise);
    rise = 0;
    for (int j = 1; j <= 100; j++) begin
      if (j <= n_drop)
        do_cycle(1'b0, 1'b1, rand_addr(), both, rand_addr(), rand_word());
      else
        do_cycle(1'b0, 1'b0, '0, 1'b0, '0, '0);
      if (obs_ready === 1'b1) begin
        rise = j;
        break;
      end
    end
  endtask

  initial begin
    int rise;
    logic [31:0] rv;
    logic [AB-1:0] a;
    n_checks = 0;
    n_fail   = 0;
    armed    = 1'b0;
    win      = 1'b0;
    win_valid = 0;
    cyc      = 0;
    m_last   = '0;
    m_ready  = 1'b0;
    m_drop   = 0;
    m_clr    = 0;
    m_rdc    = '0;
    m_wrc    = '0;
    m_col    = 0;
    rst      = 1'b1;
    rd_en    = 1'b0;
    rd_addr  = '0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;

    // Reset, then release and drop three paired requests while clearing
    do_cycle(1'b1, 1'b0, '0, 1'b0, '0, '0);
    do_cycle(1'b1, 1'b0, '0, 1'b0, '0, '0);
    do_cycle(1'b0, 1'b0, '0, 1'b0, '0, '0);
    wait_ready(3, 1'b1, rise);
    check_eq("ready_rise_cycles", CW'(rise), CW'(WORDS + 1));
    check_eq("drop_after_clear", CW'(drop_count), CW'(6));

    // Every word reads back as zero, with random upper address bits
    for (int i = 0; i < WORDS; i++) begin
      a = rand_addr();
      a[DB-1:0] = i[DB-1:0];
      do_cycle(1'b0, 1'b1, a, 1'b0, '0, '0);
    end
    idle(L + 1);

    // Write, then read the next cycle
    do_cycle(1'b0, 1'b0, '0, 1'b1, 18'd5, 144'h1234_5678_9ABC_DEF0_1234_5678_9ABC_DEF0_12AB);
    do_cycle(1'b0, 1'b1, 18'd5, 1'b0, '0, '0);
    idle(L + 1);

    // Same-cycle read and write to one index returns the old word first
    do_cycle(1'b0, 1'b1, 18'd7, 1'b1, 18'd7, {CW{1'b1}});
    do_cycle(1'b0, 1'b1, 18'd7, 1'b0, '0, '0);
    idle(L + 1);

    // Aliasing on the low index bits
    do_cycle(1'b0, 1'b0, '0, 1'b1, 18'h00403, rand_word());
    do_cycle(1'b0, 1'b1, 18'h00003, 1'b0, '0, '0);
    idle(L + 1);

    // Random traffic, including back-to-back reads and collisions
    for (int i = 0; i < 300; i++) begin
      rv = $urandom;
      do_cycle(1'b0, rv[0] | rv[1], rand_addr(), rv[2] | rv[3], rand_addr(), rand_word());
    end
    idle(L + 2);

    // Eight consecutive reads, with reset arriving after the fourth
    for (int i = 0; i < 4; i++) do_cycle(1'b0, 1'b1, rand_addr(), 1'b0, '0, '0);
    do_cycle(1'b1, 1'b1, rand_addr(), 1'b0, '0, '0);
    win = 1'b1;
    do_cycle(1'b0, 1'b1, rand_addr(), 1'b0, '0, '0);
    wait_ready(2, 1'b0, rise);
    win = 1'b0;
    check_eq("ready_rise_after_rerst", CW'(rise), CW'(WORDS + 1));
    check_eq("valid_after_rst", CW'(win_valid), CW'(0));
    check_eq("drop_after_rerst", CW'(drop_count), CW'(3));

    // The array was cleared again
    for (int i = 0; i < WORDS; i++) begin
      a = rand_addr();
      a[DB-1:0] = i[DB-1:0];
      do_cycle(1'b0, 1'b1, a, 1'b0, '0, '0);
    end
    idle(L + 2);
    check_eq("queue_drained", CW'(exp_q.size()), CW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
